i2s_receiver: RTL
=================

I2S_RECEIVER -- requirements
Module: i2s_receiver

Interface
REQ-001 Parameter: DATA_BITS, default 24, number of bits captured per channel word, range 16..32.
REQ-002 Parameter: SYNC_STAGES, default 2, number of synchronizer flops on each asynchronous I2S input, minimum 2.
REQ-003 Port: clk, in, 1, system clock; the single clock of the block.
REQ-004 Port: reset_n, in, 1, asynchronous active-low reset.
REQ-005 Port: enable, in, 1, synchronous to clk; receiver runs while high.
REQ-006 Port: i2s_bclk, in, 1, asynchronous I2S bit clock from PCM9211.
REQ-007 Port: i2s_lrclk, in, 1, asynchronous I2S word clock; low means left channel, high means right channel.
REQ-008 Port: i2s_d, in, 1, asynchronous I2S serial data, MSB first.
REQ-009 Port: clr_err, in, 1, synchronous to clk; clears frame_err.
REQ-010 Port: left_data, out, DATA_BITS, last complete left sample.
REQ-011 Port: right_data, out, DATA_BITS, last complete right sample.
REQ-012 Port: sample_valid, out, 1, one-clk pulse; left_data and right_data were updated as a pair.
REQ-013 Port: frame_err, out, 1, sticky short-word error flag.

Function
REQ-014 The block SHALL pass i2s_bclk, i2s_lrclk and i2s_d through SYNC_STAGES flops each, then detect a bclk rising edge as synced bclk going 0 to 1 between consecutive clk cycles.
REQ-015 On each detected bclk rising edge, the block SHALL sample synced lrclk and i2s_d together; no other clk cycle SHALL change the capture state.
REQ-016 An lrclk change SHALL be the sampled lrclk differing from the value sampled at the previous bclk edge; with the I2S one-bit delay, the edge after that change carries the channel MSB.
REQ-017 A 6-bit bit counter SHALL reset to 0 at each lrclk-change edge, increment on each following edge, and saturate at 63.
REQ-018 Data bits at counter values 1..DATA_BITS SHALL shift MSB-first into the channel shift register; bits beyond DATA_BITS SHALL be ignored.
REQ-019 State machine states SHALL be: WAIT_SYNC, LEFT, RIGHT.
REQ-020 WAIT_SYNC SHALL move to LEFT on an lrclk high-to-low change edge and SHALL discard all data.
REQ-021 LEFT SHALL move to RIGHT on a low-to-high change edge and latch the shift register into an internal left hold register.
REQ-022 RIGHT SHALL move to LEFT on a high-to-low change edge. On that transition, left_data SHALL take the left hold value, right_data SHALL take the shift register, and sample_valid SHALL pulse high for exactly one clk.
REQ-023 Latency: sample_valid SHALL rise exactly SYNC_STAGES+2 clk cycles after the first clk edge at which the raw i2s_bclk rising edge terminating the frame is sampled high.
REQ-024 Short word: if a change edge arrives with counter < DATA_BITS, the unfilled LSBs SHALL be zero. The word SHALL still be stored or output, and frame_err SHALL be set.
REQ-025 frame_err SHALL clear on clr_err high. If set and clear occur in the same cycle, set SHALL win.
REQ-026 When enable is low, the state SHALL force WAIT_SYNC, the counter SHALL clear, and sample_valid SHALL stay 0. left_data, right_data and frame_err SHALL hold.
REQ-027 Bit errors caused by a change edge within 1 bclk of the previous change SHALL be treated as short words, not as state errors.
REQ-028 Correct operation SHALL be guaranteed for clk frequency >= 4x bclk frequency with bclk duty cycle 40-60 %.

Reset
REQ-029 While reset_n is low, all synchronizer flops, the shift register, the hold register, the counter, left_data, right_data, sample_valid and frame_err SHALL be 0, and the state SHALL be WAIT_SYNC.
REQ-030 Reset SHALL take effect asynchronously and be released synchronously to clk. A frame in progress SHALL be discarded, and the first sample_valid after release SHALL follow a complete left then right word.

Verification
REQ-031 Normal frame: clk 100 MHz, bclk 3.072 MHz, 32-bit slots, L=0x123456, R=0xABCDEF -> at frame end, left_data=0x123456, right_data=0xABCDEF, one sample_valid pulse at the REQ-023 latency, frame_err=0.
REQ-032 Mid-frame start: enable raised while lrclk is high in the right slot -> that right word is discarded and no sample_valid occurs until the next full L/R frame completes.
REQ-033 Short slot: 16-bit slots with DATA_BITS=24, L=0xBEEF -> left_data=0xBEEF00 and frame_err=1. A clr_err pulse clears it; clr_err coincident with a new short word leaves frame_err=1.
REQ-034 Max rate: bclk=clk/4, 24-bit slots, 100 consecutive frames of incrementing data -> 100 sample_valid pulses with no lost or duplicated pairs.
REQ-035 Reset mid-operation: reset_n low for 3 clk in the middle of a right word -> all outputs read 0 immediately. The first sample_valid after release comes only after the next full frame.
REQ-036 Enable drop: enable low for 2 frames -> no sample_valid and outputs hold their prior values. After re-enable, valid pairs resume after the first complete frame.

Source files
------------

// File: rtl/i2s_receiver.sv
// I2S receiver for the PCM9211 link: synchronises bclk/lrclk/data into the clk domain
// and delivers left/right sample pairs with a one-clock valid strobe.
module i2s_receiver #(
   parameter int DATA_BITS   = 24,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 enable,
   input  logic                 i2s_bclk,
   input  logic                 i2s_lrclk,
   input  logic                 i2s_d,
   input  logic                 clr_err,
   output logic [DATA_BITS-1:0] left_data,
   output logic [DATA_BITS-1:0] right_data,
   output logic                 sample_valid,
   output logic                 frame_err
);

   typedef enum logic [1:0] {
      WAIT_SYNC,
      LEFT,
      RIGHT
   } state_t;

   localparam logic [DATA_BITS-1:0] MSB_ONE = {1'b1, {(DATA_BITS-1){1'b0}}};

   logic [1:0]             rst_pipe;
   logic                   rst_int_n;
   logic [SYNC_STAGES-1:0] bclk_sync;
   logic [SYNC_STAGES-1:0] lrclk_sync;
   logic [SYNC_STAGES-1:0] d_sync;
   logic                   bclk_s;
   logic                   bclk_q;
   logic                   rise_a;
   logic                   lr_a;
   logic                   d_a;
   logic                   rise_b;
   logic                   lr_prev;
   logic                   change_b;
   logic                   lr_b;
   logic                   d_b;
   state_t                 state;
   logic [5:0]             bit_cnt;
   logic [DATA_BITS-1:0]   shreg;
   logic [DATA_BITS-1:0]   left_hold;
   logic [DATA_BITS-1:0]   bit_mask;
   logic [DATA_BITS-1:0]   word_next;
   logic                   short_word;
   logic                   err_set;

   // Reset asserts asynchronously but is released on a clk edge
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rst_pipe <= 2'b00;
      end else begin
         rst_pipe <= {rst_pipe[0], 1'b1};
      end
   end

   assign rst_int_n = rst_pipe[1];

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         bclk_sync  <= '0;
         lrclk_sync <= '0;
         d_sync     <= '0;
      end else begin
         bclk_sync  <= {bclk_sync[SYNC_STAGES-2:0], i2s_bclk};
         lrclk_sync <= {lrclk_sync[SYNC_STAGES-2:0], i2s_lrclk};
         d_sync     <= {d_sync[SYNC_STAGES-2:0], i2s_d};
      end
   end

   assign bclk_s = bclk_sync[SYNC_STAGES-1];

   // lrclk and data share the bclk synchroniser depth, so they line up with the detected edge
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         bclk_q <= 1'b0;
         rise_a <= 1'b0;
         lr_a   <= 1'b0;
         d_a    <= 1'b0;
      end else begin
         bclk_q <= bclk_s;
         rise_a <= bclk_s & ~bclk_q;
         if (bclk_s & ~bclk_q) begin
            lr_a <= lrclk_sync[SYNC_STAGES-1];
            d_a  <= d_sync[SYNC_STAGES-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         rise_b   <= 1'b0;
         lr_prev  <= 1'b0;
         change_b <= 1'b0;
         lr_b     <= 1'b0;
         d_b      <= 1'b0;
      end else begin
         rise_b <= rise_a;
         if (rise_a) begin
            lr_prev  <= lr_a;
            change_b <= lr_a ^ lr_prev;
            lr_b     <= lr_a;
            d_b      <= d_a;
         end
      end
   end

   // The bit on a change edge is the LSB of the word just ending (one-bit I2S delay)
   always_comb begin
      bit_mask   = MSB_ONE >> bit_cnt;
      word_next  = d_b ? (shreg | bit_mask) : shreg;
      short_word = {26'd0, bit_cnt} < 32'(DATA_BITS - 1);
      err_set    = enable & rise_b & change_b & (state != WAIT_SYNC) & short_word;
   end

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state        <= WAIT_SYNC;
         bit_cnt      <= 6'd0;
         shreg        <= '0;
         left_hold    <= '0;
         left_data    <= '0;
         right_data   <= '0;
         sample_valid <= 1'b0;
      end else begin
         sample_valid <= 1'b0;
         if (!enable) begin
            state   <= WAIT_SYNC;
            bit_cnt <= 6'd0;
            shreg   <= '0;
         end else if (rise_b) begin
            if (change_b) begin
               bit_cnt <= 6'd0;
               shreg   <= '0;
               case (state)
                  WAIT_SYNC: begin
                     if (!lr_b) state <= LEFT;
                  end
                  LEFT: begin
                     if (lr_b) begin
                        state     <= RIGHT;
                        left_hold <= word_next;
                     end
                  end
                  RIGHT: begin
                     if (!lr_b) begin
                        state        <= LEFT;
                        left_data    <= left_hold;
                        right_data   <= word_next;
                        sample_valid <= 1'b1;
                     end
                  end
                  default: state <= WAIT_SYNC;
               endcase
            end else begin
               if (bit_cnt != 6'd63) bit_cnt <= bit_cnt + 6'd1;
               shreg <= word_next;
            end
         end
      end
   end

   // Setting the error takes priority over a simultaneous clear
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         frame_err <= 1'b0;
      end else if (err_set) begin
         frame_err <= 1'b1;
      end else if (clr_err && enable) begin
         frame_err <= 1'b0;
      end
   end

endmodule
